// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential signed radix-2 restoring divider (DIV/MOD)
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   start   request a new operation (accepted only while idle)
//   op_mod  0 = quotient, 1 = remainder; sampled with start
//   in1     signed dividend; sampled with start
//   in2     signed divisor; sampled with start
//   out     registered signed result, held until the next done
//   busy    high while an operation is in progress
//   done    one-cycle pulse when out is valid
//   dbz     divide-by-zero flag of the last completed operation

module div_seq #(
  parameter int NUBITS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     op_mod,
  input  logic signed [NUBITS-1:0] in1,
  input  logic signed [NUBITS-1:0] in2,
  output logic signed [NUBITS-1:0] out,
  output logic                     busy,
  output logic                     done,
  output logic                     dbz
);

  localparam int CW = $clog2(NUBITS + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [NUBITS-1:0] rem_r;
  logic [NUBITS-1:0] quo_r;
  logic [NUBITS-1:0] dvs_r;
  logic              mod_r;
  logic              neg1_r;
  logic              neg2_r;
  logic              zero_r;

  logic [NUBITS-1:0] in1_u;
  logic [NUBITS-1:0] in2_u;
  logic [NUBITS-1:0] mag1;
  logic [NUBITS-1:0] mag2;
  logic [NUBITS:0]   rem_sh;
  logic [NUBITS:0]   dvs_ext;
  logic [NUBITS:0]   diff;
  logic              fits;
  logic [NUBITS-1:0] q_signed;
  logic [NUBITS-1:0] r_signed;
  logic [NUBITS-1:0] in1_back;
  logic [NUBITS-1:0] result;

  assign busy = (state != IDLE);

  // Magnitudes as unsigned; the most negative value maps to 2^(NUBITS-1),
  // which still fits in NUBITS unsigned bits.
  assign in1_u = in1;
  assign in2_u = in2;
  assign mag1  = in1_u[NUBITS-1] ? -in1_u : in1_u;
  assign mag2  = in2_u[NUBITS-1] ? -in2_u : in2_u;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  assign rem_sh  = {rem_r, quo_r[NUBITS-1]};
  assign dvs_ext = {1'b0, dvs_r};
  assign diff    = rem_sh - dvs_ext;
  assign fits    = (rem_sh >= dvs_ext);

  // Sign fix-up. Quotient negation wraps, so MIN / -1 returns MIN.
  assign q_signed = (neg1_r ^ neg2_r) ? -quo_r : quo_r;
  assign r_signed = neg1_r ? -rem_r : rem_r;
  // On divide-by-zero quo_r still holds |in1|; restoring its sign gives in1.
  assign in1_back = neg1_r ? -quo_r : quo_r;

  always_comb begin
    result = '0;
    if (zero_r) begin
      result = mod_r ? in1_back : '1;
    end else begin
      result = mod_r ? r_signed : q_signed;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      dvs_r  <= '0;
      mod_r  <= 1'b0;
      neg1_r <= 1'b0;
      neg2_r <= 1'b0;
      zero_r <= 1'b0;
      out    <= '0;
      done   <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mod_r  <= op_mod;
            neg1_r <= in1_u[NUBITS-1];
            neg2_r <= in2_u[NUBITS-1];
            quo_r  <= mag1;
            dvs_r  <= mag2;
            rem_r  <= '0;
            cnt    <= '0;
            zero_r <= (in2_u == '0);
            state  <= (in2_u == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          rem_r <= fits ? diff[NUBITS-1:0] : rem_sh[NUBITS-1:0];
          quo_r <= {quo_r[NUBITS-2:0], fits};
          if (cnt == CW'(NUBITS - 1)) begin
            state <= FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          out   <= result;
          dbz   <= zero_r;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq with a 64-bit arithmetic reference

module tb_div_seq;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               op_mod = 1'b0;
  logic signed [31:0] in1 = '0;
  logic signed [31:0] in2 = '0;
  logic signed [31:0] out;
  logic               busy;
  logic               done;
  logic               dbz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq #(.NUBITS(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_mod(op_mod),
    .in1   (in1),
    .in2   (in2),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic truncated back to 32 bits.
  function automatic void model(input logic op, input logic signed [31:0] a,
                                input logic signed [31:0] b,
                                output logic [31:0] o, output logic z);
    longint la;
    longint lb;
    longint q;
    longint r;
    la = a;
    lb = b;
    if (b == 0) begin
      z = 1'b1;
      o = op ? a : 32'hFFFF_FFFF;
    end else begin
      z = 1'b0;
      q = la / lb;
      r = la % lb;
      o = op ? r[31:0] : q[31:0];
    end
  endfunction

  // Advances negedge by negedge until done is seen or the budget runs out.
  task automatic wait_done(inout int n);
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
  endtask

  task automatic scramble();
    in1    = $urandom;
    in2    = $urandom;
    op_mod = 1'($urandom);
  endtask

  task automatic run_op(input logic op, input logic signed [31:0] a,
                        input logic signed [31:0] b, input string tag);
    logic [31:0] exp_o;
    logic        exp_z;
    int          n;
    model(op, a, b, exp_o, exp_z);
    @(negedge clk);
    start = 1'b1; op_mod = op; in1 = a; in2 = b;
    @(negedge clk);
    start = 1'b0;
    scramble();
    chk({tag, " busy"}, busy, 1);
    n = 0;
    wait_done(n);
    chk({tag, " latency"}, n, (b == 0) ? 1 : 33);
    chk({tag, " out"}, out, exp_o);
    chk({tag, " dbz"}, dbz, exp_z);
    chk({tag, " busy_in_done"}, busy, 0);
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " out_hold"}, out, exp_o);
  endtask

  initial begin
    logic [31:0] exp_o;
    logic        exp_z;
    int          n;
    int          seen;
    logic signed [31:0] a;
    logic signed [31:0] b;

    #12;
    chk("reset out", out, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dbz", dbz, 0);
    @(negedge clk);
    rst = 1'b1;

    run_op(1'b0, 100, 7, "div 100/7");
    run_op(1'b1, -100, 7, "mod -100/7");
    run_op(1'b1, 100, -7, "mod 100/-7");
    run_op(1'b1, -100, -7, "mod -100/-7");
    run_op(1'b0, -100, 7, "div -100/7");
    run_op(1'b0, 32'sh8000_0000, -1, "div min/-1");
    run_op(1'b1, 32'sh8000_0000, -1, "mod min/-1");
    run_op(1'b0, 5, 0, "div by zero");
    run_op(1'b1, 5, 0, "mod by zero");
    run_op(1'b1, -9, 0, "mod neg by zero");
    run_op(1'b0, 100, 7, "dbz clear");

    // A start raised mid-operation must be ignored.
    model(1'b0, 1000, 33, exp_o, exp_z);
    @(negedge clk);
    start = 1'b1; op_mod = 1'b0; in1 = 1000; in2 = 33;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op_mod = 1'b1; in1 = 7; in2 = 1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored start busy", busy, 1);
    n = 10;
    wait_done(n);
    chk("ignored start latency", n, 33);
    chk("ignored start out", out, exp_o);

    // Back-to-back: start held in the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; op_mod = 1'b0; in1 = -100; in2 = 7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    wait_done(n);
    chk("b2b first latency", n, 33);
    chk("b2b first out", out, 32'hFFFF_FFF2);
    start = 1'b1; op_mod = 1'b1; in1 = 12345; in2 = -11;
    model(1'b1, 12345, -11, exp_o, exp_z);
    @(negedge clk);
    start = 1'b0;
    scramble();
    chk("b2b second busy", busy, 1);
    n = 0;
    wait_done(n);
    chk("b2b second latency", n, 33);
    chk("b2b second out", out, exp_o);

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    start = 1'b1; op_mod = 1'b0; in1 = 100; in2 = 7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort out", out, 0);
    chk("abort done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort no done", seen, 0);
    chk("abort out held", out, 0);
    run_op(1'b0, 100, 7, "after abort");

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 0;
        1: b = -1;
        2: b = $signed(32'($urandom_range(1, 20)));
        3: a = 32'sh8000_0000;
        4: b = 32'sh8000_0000;
        default: ;
      endcase
      run_op(1'($urandom), a, b, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
